// File: rtl/mag_stats_pkg.sv
// Shared defaults and record layout for the magnitude window statistics block.
// The saturation counter is built only when MAG_WINDOW_STATS_SAT_CNT_EN is defined.
package mag_stats_pkg;

  localparam int MAG_W_DEF   = 7;
  localparam int WIN_LEN_DEF = 16;
  localparam int CNT_W_DEF   = $clog2(WIN_LEN_DEF);
  localparam int SUM_W_DEF   = MAG_W_DEF + CNT_W_DEF;

  // Largest magnitude upstream can produce; it stands in for the clipped -128 input.
  localparam logic [MAG_W_DEF-1:0] MAG_SAT = '1;

  typedef struct packed {
    logic [MAG_W_DEF-1:0] peak;
    logic [SUM_W_DEF-1:0] sum;
    logic [MAG_W_DEF-1:0] mean;
    logic [CNT_W_DEF:0]   sat_cnt;
  } mag_rec_t;

endpackage

// File: rtl/mag_stats_accum.sv
// Per-window accumulator: sample count, running sum, running peak and (with
// MAG_WINDOW_STATS_SAT_CNT_EN) a count of saturated samples.
module mag_stats_accum
  import mag_stats_pkg::*;
#(
  parameter int MAG_W   = MAG_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = $clog2(WIN_LEN),
  parameter int SUM_W   = MAG_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic [MAG_W-1:0] mag,
  output logic             last,
  output logic             done,
  output logic [MAG_W-1:0] fin_peak,
  output logic [SUM_W-1:0] fin_sum
`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
  ,
  output logic [CNT_W:0]   fin_sat
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc_sum;
  logic [MAG_W-1:0] acc_peak;

  assign last     = (cnt == CNT_W'(WIN_LEN - 1));
  assign done     = accept && last;
  // Window totals include the sample being accepted this cycle.
  assign fin_peak = (mag > acc_peak) ? mag : acc_peak;
  assign fin_sum  = acc_sum + SUM_W'(mag);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt      <= '0;
      acc_sum  <= '0;
      acc_peak <= '0;
    end else if (accept) begin
      if (last) begin
        cnt      <= '0;
        acc_sum  <= '0;
        acc_peak <= '0;
      end else begin
        cnt      <= cnt + 1'b1;
        acc_sum  <= fin_sum;
        acc_peak <= fin_peak;
      end
    end
  end

`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
  logic [CNT_W:0] acc_sat;
  logic           is_sat;

  assign is_sat  = (mag == {MAG_W{1'b1}});
  assign fin_sat = acc_sat + (CNT_W+1)'(is_sat);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_sat <= '0;
    end else if (accept) begin
      acc_sat <= last ? '0 : fin_sat;
    end
  end
`endif

endmodule

// File: rtl/mag_window_stats.sv
// Windowed peak/sum/mean of a magnitude stream with a one-deep output record.
// Optional saturated-sample count under MAG_WINDOW_STATS_SAT_CNT_EN.
module mag_window_stats
  import mag_stats_pkg::*;
#(
  parameter int MAG_W   = MAG_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = $clog2(WIN_LEN),
  parameter int SUM_W   = MAG_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             win_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_peak,
  output logic [SUM_W-1:0] out_sum,
  output logic [MAG_W-1:0] out_mean
`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
  ,
  output logic [CNT_W:0]   out_sat_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready drops only when the closing sample of a window would overwrite a
  // record that the downstream has not yet taken.

  logic             accept;
  logic             last;
  logic             done;
  logic [MAG_W-1:0] fin_peak;
  logic [SUM_W-1:0] fin_sum;
`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
  logic [CNT_W:0]   fin_sat;
`endif

  assign in_ready = rst_n && !win_clr && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  mag_stats_accum #(
    .MAG_W   (MAG_W),
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W),
    .SUM_W   (SUM_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .accept   (accept),
    .mag      (in_mag),
    .last     (last),
    .done     (done),
    .fin_peak (fin_peak),
    .fin_sum  (fin_sum)
`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
    ,
    .fin_sat  (fin_sat)
`endif
  );

  // A completing window reloads the record even while the old one drains,
  // which gives back-to-back records without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_peak  <= '0;
      out_sum   <= '0;
      out_mean  <= '0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_peak  <= fin_peak;
      out_sum   <= fin_sum;
      out_mean  <= fin_sum[SUM_W-1:CNT_W];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MAG_WINDOW_STATS_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sat_cnt <= '0;
    end else if (done) begin
      out_sat_cnt <= fin_sat;
    end
  end
`endif

endmodule

// File: doc/mag_window_stats.md
Name: mag_window_stats

Overview:
- Sits directly downstream of the absolute-value stage and consumes its 7-bit unsigned magnitude stream.
- Groups accepted samples into fixed windows of WIN_LEN samples.
- Emits one record per window: peak, sum and mean.
- Valid/ready on both sides; one-deep output register so the upstream stalls only when a finished window cannot be handed off.

Parameters:
- MAG_W, 7: magnitude width; matches the absolute-value stage output.
- WIN_LEN, 16: samples per window. Must be a power of two and at least 2.
- CNT_W, $clog2(WIN_LEN): width of the sample counter (derived).
- SUM_W, MAG_W+CNT_W: width of the window sum (derived). Overflow is impossible by construction.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- win_clr  in  1  synchronous clear; discards the partial window.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_mag  in  MAG_W  unsigned magnitude sample.
- out_valid  out  1  window record valid.
- out_ready  in  1  downstream accepts the record.
- out_peak  out  MAG_W  maximum magnitude in the window.
- out_sum  out  SUM_W  sum of the window's magnitudes.
- out_mean  out  MAG_W  out_sum >> CNT_W (truncating).
- out_sat_cnt  out  CNT_W+1  present only with the macro; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clock edge): cnt=0, acc_peak=0, acc_sum=0, out_valid=0, out_peak=0, out_sum=0, out_mean=0 (out_sat_cnt=0 when present).
- Reset applied mid-window or mid-handshake discards everything. No record is emitted for that window.
- Accept condition: in_valid && in_ready.
- in_ready = rst_n && !win_clr && !(cnt==WIN_LEN-1 && out_valid && !out_ready).
  - Stalls only on the last sample of a window while the previous record is still pending.
- On accept with cnt<WIN_LEN-1:
  - cnt+=1
  - acc_sum+=in_mag
  - acc_peak=max(acc_peak,in_mag)
- On accept with cnt==WIN_LEN-1 (window complete):
  - Output registers load peak=max(acc_peak,in_mag), sum=acc_sum+in_mag, mean=sum>>CNT_W. The last sample is included.
  - out_valid=1 on the next cycle. Latency is 1 clock from the last accepted sample.
  - cnt, acc_sum and acc_peak return to 0 in the same edge.
- Output handshake:
  - On out_valid && out_ready, out_valid clears next cycle unless a new window completes in the same cycle.
  - If a new window completes in that same cycle, the registers reload and out_valid stays 1. Back-to-back records with no bubble.
- Output registers hold their values while out_valid && !out_ready.
- win_clr=1:
  - cnt, acc_sum and acc_peak clear next edge.
  - in_ready=0, so a simultaneous sample is not taken.
  - A pending output record is unaffected and still honours out_ready.
- in_valid without in_ready: the sample is not consumed. Upstream must hold in_mag.
- Magnitude of all-ones (127) is a legal value. No special casing in peak or sum.
- Arithmetic: all unsigned. acc_sum zero-extends in_mag to SUM_W.

Optional Feature:
- Macro MAG_WINDOW_STATS_SAT_CNT_EN.
- When defined:
  - Port out_sat_cnt exists.
  - acc_sat counts accepted samples with in_mag == all ones (the saturated -128 case from upstream).
  - acc_sat is loaded into out_sat_cnt at window completion, with the same timing as out_peak.
  - acc_sat clears on reset, win_clr and window completion.
- When undefined: neither the port nor the counter exists. All other behaviour is identical.

Decomposition:
- Package mag_stats_pkg:
  - MAG_W default
  - record typedef (peak, sum, mean, sat_cnt)
  - constant for the all-ones saturation value
- One sub-module, mag_stats_accum, holds cnt, acc_sum, acc_peak and acc_sat and flags window completion.
- The top level owns the output register and both handshakes.

Test Plan:
- 16 samples 0..15, out_ready=1 → one record with peak=15, sum=120, mean=7, one clock after the 16th accept.
- 16 samples all 127 (macro on) → peak=127, sum=2032, mean=127, sat_cnt=16. With the macro off, the record is identical and the port is absent.
- out_ready=0 after window 1; stream window 2 → 15 samples accepted, in_ready=0 on the 16th. Raise out_ready → record 1 drains, the 16th sample is accepted the same cycle, record 2 is valid the next cycle.
- 5 samples of 100, then win_clr for 1 cycle with in_valid=1, then 16 samples of 2 → single record peak=2, sum=32, mean=2. The sample presented during win_clr is not consumed.
- rst_n=0 after 10 samples, while out_valid=1 → all outputs 0 next cycle. A following full window of 3s gives peak=3, sum=48, mean=3.
- Continuous samples with out_ready=1 → records on consecutive windows with in_ready never deasserted and no lost samples.
